// File: rtl/voice_ram_arbiter_pkg.sv
// ============================================================================
// voice_ram_arbiter_pkg : shared voice RAM sizing, read-owner encoding, helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package voice_ram_arbiter_pkg;

    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 32;
    localparam int CHUNK_COUNT = 2830;
    localparam int DEFER_W     = 8;

    localparam logic [DEFER_W-1:0] DEFER_MAX = '1;

    // Bit positions of the two readers inside the round-robin request vector
    localparam int RD_PLAY = 0;
    localparam int RD_DBG  = 1;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_PLAY = 2'd1,
        OWNER_DBG  = 2'd2
    } owner_e;

    function automatic logic [DEFER_W-1:0] sat_inc(input logic [DEFER_W-1:0] v);
        return (v == DEFER_MAX) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/voice_ram_arbiter_if.sv
// ============================================================================
// voice_ram_arbiter_if : recorder / playback / debug requester bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface voice_ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              rec_wr;
    logic [ADDR_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_data;

    logic              play_req;
    logic [ADDR_W-1:0] play_addr;
    logic              play_gnt;
    logic              play_rvalid;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;

    logic [DATA_W-1:0] rd_data;

    modport master (
        output rec_wr, rec_addr, rec_data,
        output play_req, play_addr,
        output dbg_req, dbg_addr,
        input  play_gnt, play_rvalid, dbg_gnt, dbg_rvalid, rd_data
    );

    modport slave (
        input  rec_wr, rec_addr, rec_data,
        input  play_req, play_addr,
        input  dbg_req, dbg_addr,
        output play_gnt, play_rvalid, dbg_gnt, dbg_rvalid, rd_data
    );

endinterface

`default_nettype wire

// File: rtl/voice_ram_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-requester round-robin arbiter with a registered favour pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       en_i,
    input  wire logic [1:0] req_i,
    output logic      [1:0] gnt_o
);

    // ptr_q = 0 favours req_i[0] on a tie, 1 favours req_i[1]
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i[0] && (!req_i[1] || !ptr_q)) begin
                gnt_o[0] = 1'b1;
            end else if (req_i[1]) begin
                gnt_o[1] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/voice_ram_arbiter.sv
// ============================================================================
// voice_ram_arbiter : recorder-first, round-robin read arbiter for voice RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module voice_ram_arbiter
    import voice_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = voice_ram_arbiter_pkg::ADDR_W,
    parameter int DATA_W = voice_ram_arbiter_pkg::DATA_W
) (
    input  wire logic                clk,
    input  wire logic                rst,
    voice_ram_arbiter_if.slave       bus,
    output logic                     ram_en_o,
    output logic                     ram_we_o,
    output logic [ADDR_W-1:0]        ram_addr_o,
    output logic [DATA_W-1:0]        ram_wdata_o,
    input  wire logic [DATA_W-1:0]   ram_rdata_i,
    output logic [DEFER_W-1:0]       defer_cnt_o
);

    logic [1:0]         w_req;
    logic [1:0]         w_gnt;
    logic               w_rd_allow;
    logic               w_deferred;

    owner_e             owner_q;
    logic               play_rvalid_q;
    logic               dbg_rvalid_q;
    logic [DATA_W-1:0]  rd_hold_q;
    logic [DEFER_W-1:0] defer_q;
    logic [DEFER_W-1:0] defer_d;

    assign w_req      = {bus.dbg_req, bus.play_req};
    assign w_rd_allow = !rst && !bus.rec_wr;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .en_i  (w_rd_allow),
        .req_i (w_req),
        .gnt_o (w_gnt)
    );

    assign bus.play_gnt = w_gnt[RD_PLAY];
    assign bus.dbg_gnt  = w_gnt[RD_DBG];

    // One access per cycle: the recorder write pre-empts any read grant
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (!rst) begin
            if (bus.rec_wr) begin
                ram_en_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = bus.rec_addr;
                ram_wdata_o = bus.rec_data;
            end else if (w_gnt[RD_PLAY]) begin
                ram_en_o    = 1'b1;
                ram_addr_o  = bus.play_addr;
            end else if (w_gnt[RD_DBG]) begin
                ram_en_o    = 1'b1;
                ram_addr_o  = bus.dbg_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q       <= OWNER_NONE;
            play_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
        end else begin
            if (w_gnt[RD_PLAY]) begin
                owner_q       <= OWNER_PLAY;
                play_rvalid_q <= 1'b1;
                dbg_rvalid_q  <= 1'b0;
            end else if (w_gnt[RD_DBG]) begin
                owner_q       <= OWNER_DBG;
                play_rvalid_q <= 1'b0;
                dbg_rvalid_q  <= 1'b1;
            end else begin
                owner_q       <= OWNER_NONE;
                play_rvalid_q <= 1'b0;
                dbg_rvalid_q  <= 1'b0;
            end
        end
    end

    assign bus.play_rvalid = play_rvalid_q;
    assign bus.dbg_rvalid  = dbg_rvalid_q;

    // RAM output is already a register; during the owner cycle it is forwarded
    // and latched so rd_data keeps the last returned word afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_hold_q <= '0;
        end else if (owner_q != OWNER_NONE) begin
            rd_hold_q <= ram_rdata_i;
        end
    end

    assign bus.rd_data = (owner_q != OWNER_NONE) ? ram_rdata_i : rd_hold_q;

    assign w_deferred = bus.rec_wr && (bus.play_req || bus.dbg_req);

    always_comb begin
        defer_d = defer_q;
        if (w_deferred) begin
            defer_d = sat_inc(defer_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            defer_q <= '0;
        end else begin
            defer_q <= defer_d;
        end
    end

    assign defer_cnt_o = defer_q;

endmodule

`default_nettype wire
